// File: rtl/fft_pkg.sv
// Shared constants, controller states and twiddle group map for the
// 16-point radix-2 SDF FFT sequencing controller.
package fft_pkg;

  localparam int N       = 16;
  localparam int LOGN    = 4;
  localparam int LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The stage-1 group index m[3:2] arrives in bit-reversed order relative
  // to the twiddle stride it needs.
  function automatic logic [1:0] tw_group(input logic [1:0] q);
    logic [1:0] g;
    case (q)
      2'd0:    g = 2'd0;
      2'd1:    g = 2'd2;
      2'd2:    g = 2'd1;
      default: g = 2'd3;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/valid_pipe.sv
// Fixed-depth shift register carrying per-sample markers alongside the
// SDF datapath; clr wipes every in-flight marker in one clock.
module valid_pipe #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], din};
    if (clr) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencing controller for a 16-point radix-2 SDF FFT: frame counting,
// butterfly selects, twiddle addressing, drain and output valid/sof tracking.
module fft_seq_ctrl #(
  parameter int N       = fft_pkg::N,
  parameter int LATENCY = fft_pkg::LATENCY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_zero_in,
  output logic [3:0] o_sel,
  output logic [3:0] o_tw_addr,
  output logic       o_valid,
  output logic       o_sof,
  output logic       o_busy,
  output logic       o_err
);
  import fft_pkg::*;

  localparam int CNT_W  = $clog2(N);
  localparam int FCNT_W = $clog2(LATENCY);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                err_q, err_d;
  logic                accept;
  logic [1:0]          pipe_out;
  logic [CNT_W-1:0]    tw_m;
  logic [1:0]          tw_g;
  logic [3:0]          tw_prod;

  // Readiness depends on registered state only, so i_valid never loops back.
  assign o_ready = (state_q != FLUSH) || (cnt_q == '0);
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        fcnt_d = '0;
        if (i_valid) begin
          state_d = RUN;
          cnt_d   = CNT_W'(1);
        end
      end
      RUN: begin
        if (i_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q == '0) begin
          state_d = FLUSH;
          fcnt_d  = '0;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      FLUSH: begin
        cnt_d  = cnt_q + CNT_W'(1);
        fcnt_d = fcnt_q + FCNT_W'(1);
        // A new frame starting on the boundary wins over ending the drain.
        if (accept) begin
          state_d = RUN;
          fcnt_d  = '0;
        end else if (fcnt_q == FCNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          fcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

  valid_pipe #(
    .WIDTH(2),
    .DEPTH(LATENCY)
  ) u_valid_pipe (
    .clk (clk),
    .rst (rst),
    .clr (err_d),
    .din ({accept, accept && (cnt_q == '0)}),
    .dout(pipe_out)
  );

  // Twiddle index is taken four samples ahead to line up with stage 1.
  assign tw_m    = cnt_q + CNT_W'(4);
  assign tw_g    = tw_group(tw_m[3:2]);
  assign tw_prod = {2'b00, tw_m[1:0]} * {2'b00, tw_g};

  assign o_busy    = (state_q != IDLE);
  assign o_zero_in = (state_q == FLUSH);
  assign o_sel     = o_busy ? {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]} : 4'd0;
  assign o_tw_addr = o_busy ? tw_prod : 4'd0;
  assign o_valid   = pipe_out[1];
  assign o_sof     = pipe_out[0];
  assign o_err     = err_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed self-checking bench for fft_seq_ctrl: framing, flush, error gap,
// back-to-back frames, twiddle sweep and asynchronous reset behaviour.
module tb_fft_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic       o_zero_in;
  logic [3:0] o_sel;
  logic [3:0] o_tw_addr;
  logic       o_valid;
  logic       o_sof;
  logic       o_busy;
  logic       o_err;

  int total = 0;
  int bad   = 0;

  localparam logic [13:0] RST_VEC = 14'b1_0_0000_0000_0_0_0_0;

  fft_seq_ctrl #(
    .N      (16),
    .LATENCY(15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_zero_in(o_zero_in),
    .o_sel    (o_sel),
    .o_tw_addr(o_tw_addr),
    .o_valid  (o_valid),
    .o_sof    (o_sof),
    .o_busy   (o_busy),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] out_vec();
    return {o_ready, o_zero_in, o_sel, o_tw_addr, o_valid, o_sof, o_busy, o_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    tick();
    tick();
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++;
      $display("[TB] FAIL reset_hold got=%b exp=%b", out_vec(), RST_VEC);
    end
    rst = 1'b0;
    tick();
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++;
      $display("[TB] FAIL reset_release got=%b exp=%b", out_vec(), RST_VEC);
    end
  endtask

  task automatic test_single_frame();
    logic [6:0] got, exp;
    for (int t = 1; t <= 40; t++) begin
      i_valid = (t <= 16);
      tick();
      exp = {(t >= 15 && t <= 30), (t == 15), (t <= 31), (t >= 17 && t <= 31),
             ((t <= 31) && ((t % 16) >= 8)), !(t >= 17 && t <= 31), 1'b0};
      got = {o_valid, o_sof, o_busy, o_zero_in, o_sel[0], o_ready, o_err};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL single_frame t=%0d got=%b exp=%b", t, got, exp);
      end
    end
  endtask

  task automatic test_tw_sweep();
    logic [3:0] tw_tab [16] = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd0, 4'd1, 4'd2, 4'd3,
                                4'd0, 4'd3, 4'd6, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] cv;
    logic [7:0] got, exp;
    for (int j = 1; j <= 16; j++) begin
      i_valid = 1'b1;
      tick();
      cv  = 4'(j % 16);
      exp = {tw_tab[cv], cv[0], cv[1], cv[2], cv[3]};
      got = {o_tw_addr, o_sel};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL tw_sweep cnt=%0d got=%h exp=%h", cv, got, exp);
      end
    end
    i_valid = 1'b0;
    for (int j = 0; j < 20; j++) tick();
    total++;
    if ({o_busy, o_tw_addr, o_sel} !== 9'd0) begin
      bad++;
      $display("[TB] FAIL tw_idle got=%b exp=0", {o_busy, o_tw_addr, o_sel});
    end
  endtask

  task automatic test_continuous();
    logic [3:0] got, exp;
    for (int t = 1; t <= 70; t++) begin
      i_valid = (t <= 48);
      tick();
      exp = {(t >= 15 && t <= 62), (t == 15 || t == 31 || t == 47), 1'b0, (t <= 63)};
      got = {o_valid, o_sof, o_err, o_busy};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL continuous t=%0d got=%b exp=%b", t, got, exp);
      end
    end
  endtask

  task automatic test_gap_err();
    int nvalid = 0;
    for (int t = 1; t <= 5; t++) begin
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    tick();
    total++;
    if ({o_err, o_busy, o_ready} !== 3'b101) begin
      bad++;
      $display("[TB] FAIL gap_err_pulse got=%b exp=101", {o_err, o_busy, o_ready});
    end
    tick();
    total++;
    if ({o_err, o_busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL gap_err_single got=%b exp=00", {o_err, o_busy});
    end
    for (int t = 0; t < 20; t++) begin
      if (o_valid === 1'b1 || o_err === 1'b1) nvalid++;
      tick();
    end
    total++;
    if (nvalid != 0) begin
      bad++;
      $display("[TB] FAIL gap_no_valid got=%0d exp=0", nvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] got, exp;
    for (int t = 1; t <= 19; t++) begin
      i_valid = (t <= 16);
      tick();
    end
    i_valid = 1'b1;
    total++;
    if ({o_ready, o_zero_in} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL b2b_blocked got=%b exp=01", {o_ready, o_zero_in});
    end
    for (int t = 20; t <= 70; t++) begin
      i_valid = (t <= 48);
      tick();
      exp = {((t <= 30) || (t >= 47 && t <= 62)), (t == 47)};
      got = {o_valid, o_sof};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL b2b t=%0d got=%b exp=%b", t, got, exp);
      end
    end
  endtask

  task automatic test_reset_flush();
    int nvalid = 0;
    for (int t = 1; t <= 20; t++) begin
      i_valid = (t <= 16);
      tick();
    end
    total++;
    if ({o_valid, o_zero_in} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL rflush_populated got=%b exp=11", {o_valid, o_zero_in});
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++;
      $display("[TB] FAIL rflush_async got=%b exp=%b", out_vec(), RST_VEC);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (o_valid !== 1'b0) nvalid++;
    end
    total++;
    if (nvalid != 0) begin
      bad++;
      $display("[TB] FAIL rflush_no_valid got=%0d exp=0", nvalid);
    end
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++;
      $display("[TB] FAIL rflush_idle got=%b exp=%b", out_vec(), RST_VEC);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    test_reset();
    test_single_frame();
    test_tw_sweep();
    test_continuous();
    test_gap_err();
    test_back_to_back();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
